// File: rtl/rs_bank.sv
// rs_bank: multi-entry reservation station for the out-of-order OTTER.
//
// Holds DEPTH registered entries. Each entry stores a task (alu_fun and
// mem_type) and three sources. Each source has a tag, a value and a ready
// bit. Every valid entry snoops the CDB each cycle. The oldest entry with all
// sources ready is presented to the functional unit.
//
// Ports:
//   CLK, RST_N (async, active low), FLUSH (sync clear)
//   DISPATCH_VALID/READY, DISPATCH_TASK, T1..T3, A, B, RS2_DATA  - dispatch side
//   cdb_in                                                      - CDB snoop
//   ISSUE_VALID/READY, V1..V3, rd_tag, alu_fun, mem_type        - FU side
//   COUNT, BUSY                                                 - occupancy
//
// Optional feature macro: RS_BANK_CDB_WAKEUP_BYPASS_EN.
//   When defined, a CDB broadcast that completes an entry's last missing
//   source makes that entry selectable in the same cycle.
//   When undefined, select uses only registered ready bits.

package rs_bank_pkg;
    typedef logic [4:0] RS_tag_type;
    localparam RS_tag_type INVALID = 5'd0;

    typedef struct packed {
        logic [6:0] opcode;
        logic [3:0] alu_fun;
        logic [2:0] mem_type;
    } task_t;

    typedef struct packed {
        RS_tag_type  tag;
        logic [31:0] data;
    } cdb_t;
endpackage

module rs_bank
    import rs_bank_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter RS_tag_type  TAG_BASE = RS_tag_type'(INVALID + 5'd1),
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          FLUSH,
    input  logic          DISPATCH_VALID,
    output logic          DISPATCH_READY,
    input  task_t         DISPATCH_TASK,
    input  RS_tag_type    T1,
    input  RS_tag_type    T2,
    input  RS_tag_type    T3,
    input  logic [31:0]   A,
    input  logic [31:0]   B,
    input  logic [31:0]   RS2_DATA,
    input  cdb_t          cdb_in,
    output logic          ISSUE_VALID,
    input  logic          ISSUE_READY,
    output logic [31:0]   V1,
    output logic [31:0]   V2,
    output logic [31:0]   V3,
    output RS_tag_type    rd_tag,
    output logic [3:0]    alu_fun,
    output logic [2:0]    mem_type,
    output logic [CW-1:0] COUNT,
    output logic          BUSY
);

    // Entry state
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [3:0]       alu_q  [DEPTH];
    logic [3:0]       alu_d  [DEPTH];
    logic [2:0]       mem_q  [DEPTH];
    logic [2:0]       mem_d  [DEPTH];
    RS_tag_type       tag_q  [DEPTH][3];
    RS_tag_type       tag_d  [DEPTH][3];
    logic [31:0]      val_q  [DEPTH][3];
    logic [31:0]      val_d  [DEPTH][3];
    logic [2:0]       rdy_q  [DEPTH];
    logic [2:0]       rdy_d  [DEPTH];
    // older_q[j][i] = 1 when entry j was allocated before entry i. This age
    // matrix is the per-entry age rank, so freeing an entry leaves the
    // relative order of the rest unchanged.
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    logic             cdb_hit;
    logic [2:0]       match   [DEPTH];
    logic [2:0]       eff_rdy [DEPTH];
    logic [31:0]      eff_val [DEPTH][3];
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] sel;
    logic [DEPTH-1:0] alloc;
    logic             disp_fire;
    logic             issue_fire;
    RS_tag_type       disp_tag [3];
    logic [31:0]      disp_val [3];

    assign cdb_hit     = (cdb_in.tag != INVALID);
    assign disp_tag[0] = T1;
    assign disp_tag[1] = T2;
    assign disp_tag[2] = T3;
    assign disp_val[0] = A;
    assign disp_val[1] = B;
    assign disp_val[2] = RS2_DATA;

    // Wake-up match and effective readiness per entry/source
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        for (genvar gs = 0; gs < 3; gs++) begin : g_src
            assign match[gi][gs] = cdb_hit && valid_q[gi] && !rdy_q[gi][gs]
                                   && (tag_q[gi][gs] == cdb_in.tag);
`ifdef RS_BANK_CDB_WAKEUP_BYPASS_EN
            assign eff_rdy[gi][gs] = rdy_q[gi][gs] | match[gi][gs];
            assign eff_val[gi][gs] = rdy_q[gi][gs] ? val_q[gi][gs] : cdb_in.data;
`else
            assign eff_rdy[gi][gs] = rdy_q[gi][gs];
            assign eff_val[gi][gs] = val_q[gi][gs];
`endif
        end
        assign cand[gi] = valid_q[gi] & (&eff_rdy[gi]);
    end

    // Oldest-ready select. The age matrix is a strict order, so sel is one-hot or zero.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (cand[j] && older_q[j][i]) blocked = 1'b1;
            end
            sel[i] = cand[i] & ~blocked;
        end
    end

    // Lowest free entry. The choice comes from registered valid bits, so a
    // slot freed this cycle is not reused until the next cycle.
    always_comb begin
        logic found;
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !found) begin
                alloc[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Issue output mux
    always_comb begin
        ISSUE_VALID = |sel;
        V1          = '0;
        V2          = '0;
        V3          = '0;
        rd_tag      = INVALID;
        alu_fun     = '0;
        mem_type    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                V1       = eff_val[i][0];
                V2       = eff_val[i][1];
                V3       = eff_val[i][2];
                rd_tag   = TAG_BASE + RS_tag_type'(i);
                alu_fun  = alu_q[i];
                mem_type = mem_q[i];
            end
        end
    end

    assign BUSY           = (count_q == CW'(DEPTH));
    assign DISPATCH_READY = !BUSY;
    assign COUNT          = count_q;
    assign disp_fire      = DISPATCH_VALID && DISPATCH_READY;
    assign issue_fire     = ISSUE_VALID && ISSUE_READY;

    // Next-state logic
    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        tag_d   = tag_q;
        val_d   = val_q;
        rdy_d   = rdy_q;
        older_d = older_q;
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 3; s++) begin
                if (match[i][s]) begin
                    rdy_d[i][s] = 1'b1;
                    val_d[i][s] = cdb_in.data;
                end
            end
            if (issue_fire && sel[i]) valid_d[i] = 1'b0;
            if (disp_fire && alloc[i]) begin
                valid_d[i] = 1'b1;
                alu_d[i]   = DISPATCH_TASK.alu_fun;
                mem_d[i]   = DISPATCH_TASK.mem_type;
                for (int s = 0; s < 3; s++) begin
                    tag_d[i][s] = disp_tag[s];
                    if (disp_tag[s] == INVALID) begin
                        rdy_d[i][s] = 1'b1;
                        val_d[i][s] = disp_val[s];
                    end else if (cdb_hit && (disp_tag[s] == cdb_in.tag)) begin
                        rdy_d[i][s] = 1'b1;
                        val_d[i][s] = cdb_in.data;
                    end else begin
                        rdy_d[i][s] = 1'b0;
                        val_d[i][s] = '0;
                    end
                end
                // The new entry is younger than every other entry.
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[i][j] = 1'b0;
                    older_d[j][i] = (j != i);
                end
            end
        end
        if (FLUSH) valid_d = '0;

        if (FLUSH) count_d = '0;
        else       count_d = count_q + CW'(disp_fire) - CW'(issue_fire);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                alu_q[i]   <= '0;
                mem_q[i]   <= '0;
                rdy_q[i]   <= '0;
                older_q[i] <= '0;
                for (int s = 0; s < 3; s++) begin
                    tag_q[i][s] <= INVALID;
                    val_q[i][s] <= '0;
                end
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            tag_q   <= tag_d;
            val_q   <= val_d;
            rdy_q   <= rdy_d;
            older_q <= older_d;
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
module tb_rs_bank;
    import rs_bank_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        FLUSH;
    logic        DISPATCH_VALID;
    logic        DISPATCH_READY;
    task_t       DISPATCH_TASK;
    RS_tag_type  T1, T2, T3;
    logic [31:0] A, B, RS2_DATA;
    cdb_t        cdb;
    logic        ISSUE_VALID;
    logic        ISSUE_READY;
    logic [31:0] V1, V2, V3;
    RS_tag_type  rd_tag;
    logic [3:0]  alu_fun;
    logic [2:0]  mem_type;
    logic [2:0]  COUNT;
    logic        BUSY;

    rs_bank dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .DISPATCH_VALID(DISPATCH_VALID), .DISPATCH_READY(DISPATCH_READY),
        .DISPATCH_TASK(DISPATCH_TASK), .T1(T1), .T2(T2), .T3(T3),
        .A(A), .B(B), .RS2_DATA(RS2_DATA), .cdb_in(cdb),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY),
        .V1(V1), .V2(V2), .V3(V3), .rd_tag(rd_tag),
        .alu_fun(alu_fun), .mem_type(mem_type),
        .COUNT(COUNT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] v1, v2, v3;
        logic [4:0]  tag;
        logic [3:0]  alu;
        logic [2:0]  mem;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic push_exp(input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3,
                            input logic [4:0] tag, input logic [3:0] alu, input logic [2:0] mem);
        exp_t e;
        e.v1 = v1; e.v2 = v2; e.v3 = v3; e.tag = tag; e.alu = alu; e.mem = mem;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted issue is compared against the scoreboard head.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && ISSUE_VALID === 1'b1 && ISSUE_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("issue_unexpected", {27'd0, rd_tag}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("issue tag=%0d V1=0x%0h V2=0x%0h V3=0x%0h alu=%0d mem=%0d",
                         rd_tag, V1, V2, V3, alu_fun, mem_type);
                chk("issue_V1", V1, e.v1);
                chk("issue_V2", V2, e.v2);
                chk("issue_V3", V3, e.v3);
                chk("issue_tag", {27'd0, rd_tag}, {27'd0, e.tag});
                chk("issue_alu", {28'd0, alu_fun}, {28'd0, e.alu});
                chk("issue_mem", {29'd0, mem_type}, {29'd0, e.mem});
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic disp(input RS_tag_type t1, input RS_tag_type t2, input RS_tag_type t3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic [3:0] alu, input logic [2:0] mem);
        DISPATCH_VALID         = 1'b1;
        T1 = t1; T2 = t2; T3 = t3;
        A = a; B = b; RS2_DATA = r;
        DISPATCH_TASK.opcode   = 7'h33;
        DISPATCH_TASK.alu_fun  = alu;
        DISPATCH_TASK.mem_type = mem;
        $display("dispatch T=%0d/%0d/%0d A=0x%0h B=0x%0h R=0x%0h alu=%0d mem=%0d",
                 t1, t2, t3, a, b, r, alu, mem);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; FLUSH = 1'b0; DISPATCH_VALID = 1'b0; ISSUE_READY = 1'b0;
        DISPATCH_TASK = '0; T1 = INVALID; T2 = INVALID; T3 = INVALID;
        A = '0; B = '0; RS2_DATA = '0; cdb = '0;
        #1;
        chk("rst_issue_valid", {31'd0, ISSUE_VALID}, 32'd0);
        chk("rst_count", {29'd0, COUNT}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_dispatch_ready", {31'd0, DISPATCH_READY}, 32'd1);
        chk("rst_rd_tag", {27'd0, rd_tag}, 32'd0);
        next_cycle();
        next_cycle();
        RST_N = 1'b1;

        // Ready dispatch: entry 0, tag 1
        next_cycle();
        disp(INVALID, INVALID, INVALID, 32'd5, 32'd7, 32'd9, 4'd3, 3'd1);
        push_exp(32'd5, 32'd7, 32'd9, 5'd1, 4'd3, 3'd1);
        settle();
        chk("ready_no_same_cycle", {31'd0, ISSUE_VALID}, 32'd0);
        next_cycle();
        DISPATCH_VALID = 1'b0;
        ISSUE_READY = 1'b1;
        settle();
        chk("ready_issue_valid", {31'd0, ISSUE_VALID}, 32'd1);
        chk("ready_count1", {29'd0, COUNT}, 32'd1);
        next_cycle();
        ISSUE_READY = 1'b0;
        settle();
        chk("ready_count0", {29'd0, COUNT}, 32'd0);

        // CDB wake-up on tag 20
        next_cycle();
        disp(5'd20, INVALID, INVALID, 32'hAAAA, 32'd2, 32'd3, 4'd4, 3'd2);
        push_exp(32'hDEAD, 32'd2, 32'd3, 5'd1, 4'd4, 3'd2);
        next_cycle();
        DISPATCH_VALID = 1'b0;
        settle();
        chk("wake_waiting", {31'd0, ISSUE_VALID}, 32'd0);
        next_cycle();
        cdb.tag = 5'd20; cdb.data = 32'hDEAD;
        settle();
`ifdef RS_BANK_CDB_WAKEUP_BYPASS_EN
        chk("wake_bypass_valid", {31'd0, ISSUE_VALID}, 32'd1);
        chk("wake_bypass_V1", V1, 32'hDEAD);
`else
        chk("wake_cycle_n_valid", {31'd0, ISSUE_VALID}, 32'd0);
`endif
        next_cycle();
        cdb = '0;
        ISSUE_READY = 1'b1;
        settle();
        chk("wake_n1_valid", {31'd0, ISSUE_VALID}, 32'd1);
        next_cycle();
        ISSUE_READY = 1'b0;

        // Oldest-first: E0 (tag 1) older than E1 (tag 2), both wait on tag 21
        disp(INVALID, 5'd21, INVALID, 32'd10, 32'd0, 32'd11, 4'd5, 3'd3);
        push_exp(32'd10, 32'hBEEF, 32'd11, 5'd1, 4'd5, 3'd3);
        next_cycle();
        disp(INVALID, 5'd21, INVALID, 32'd12, 32'd0, 32'd13, 4'd6, 3'd4);
        push_exp(32'd12, 32'hBEEF, 32'd13, 5'd2, 4'd6, 3'd4);
        next_cycle();
        DISPATCH_VALID = 1'b0;
        cdb.tag = 5'd21; cdb.data = 32'hBEEF;
        next_cycle();
        cdb = '0;
        ISSUE_READY = 1'b1;
        settle();
        chk("oldest_first_tag", {27'd0, rd_tag}, 32'd1);
        next_cycle();
        settle();
        chk("oldest_second_tag", {27'd0, rd_tag}, 32'd2);
        next_cycle();
        ISSUE_READY = 1'b0;
        settle();
        chk("oldest_count0", {29'd0, COUNT}, 32'd0);

        // Full bank, backpressure, and age preserved across a free
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            disp(INVALID, INVALID, INVALID, 32'(100 + k), 32'(200 + k), 32'(300 + k),
                 4'(k), 3'(k));
            push_exp(32'(100 + k), 32'(200 + k), 32'(300 + k), 5'(k + 1), 4'(k), 3'(k));
        end
        push_exp(32'd400, 32'd401, 32'd402, 5'd1, 4'd9, 3'd5);
        next_cycle();
        disp(INVALID, INVALID, INVALID, 32'd400, 32'd401, 32'd402, 4'd9, 3'd5);
        settle();
        chk("full_busy", {31'd0, BUSY}, 32'd1);
        chk("full_dispatch_ready", {31'd0, DISPATCH_READY}, 32'd0);
        chk("full_count", {29'd0, COUNT}, 32'd4);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            settle();
            chk("bp_tag", {27'd0, rd_tag}, 32'd1);
            chk("bp_V1", V1, 32'd100);
            chk("bp_count", {29'd0, COUNT}, 32'd4);
        end
        next_cycle();
        ISSUE_READY = 1'b1;
        settle();
        chk("full_held_not_ready", {31'd0, DISPATCH_READY}, 32'd0);
        next_cycle();
        ISSUE_READY = 1'b0;
        settle();
        chk("freed_dispatch_ready", {31'd0, DISPATCH_READY}, 32'd1);
        chk("freed_count", {29'd0, COUNT}, 32'd3);
        chk("freed_next_oldest", {27'd0, rd_tag}, 32'd2);
        next_cycle();
        DISPATCH_VALID = 1'b0;
        settle();
        chk("held_written_count", {29'd0, COUNT}, 32'd4);
        ISSUE_READY = 1'b1;
        for (int c = 0; c < 4; c++) next_cycle();
        ISSUE_READY = 1'b0;
        settle();
        chk("drain_count", {29'd0, COUNT}, 32'd0);

        // Flush together with a dispatch
        next_cycle();
        disp(INVALID, INVALID, INVALID, 32'd1, 32'd2, 32'd3, 4'd1, 3'd1);
        next_cycle();
        disp(INVALID, INVALID, INVALID, 32'd4, 32'd5, 32'd6, 4'd2, 3'd2);
        FLUSH = 1'b1;
        next_cycle();
        FLUSH = 1'b0;
        DISPATCH_VALID = 1'b0;
        settle();
        chk("flush_count", {29'd0, COUNT}, 32'd0);
        chk("flush_issue_valid", {31'd0, ISSUE_VALID}, 32'd0);

        // Reset mid-wake-up
        next_cycle();
        disp(5'd22, INVALID, INVALID, 32'd0, 32'd8, 32'd9, 4'd7, 3'd6);
        next_cycle();
        DISPATCH_VALID = 1'b0;
        cdb.tag = 5'd22; cdb.data = 32'h1234;
        settle();
        RST_N = 1'b0;
        #1;
        chk("midrst_issue_valid", {31'd0, ISSUE_VALID}, 32'd0);
        chk("midrst_V1", V1, 32'd0);
        chk("midrst_V2", V2, 32'd0);
        chk("midrst_rd_tag", {27'd0, rd_tag}, 32'd0);
        chk("midrst_alu", {28'd0, alu_fun}, 32'd0);
        chk("midrst_count", {29'd0, COUNT}, 32'd0);
        chk("midrst_dispatch_ready", {31'd0, DISPATCH_READY}, 32'd1);
        cdb = '0;
        next_cycle();
        RST_N = 1'b1;
        next_cycle();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rs_bank.md
# rs_bank

Multi-entry reservation station for the out-of-order OTTER. It replaces the single-slot, combinational per-FU station with a registered bank of `DEPTH` entries that snoops the CDB every cycle and issues the oldest fully-ready entry to its functional unit. One instance sits between the issue queue and each FU: ALU, load, or store.

## Interface
- `DEPTH`, default 4: number of entries; legal range 2..16.
- `TAG_BASE`, default `INVALID`+1: RS_tag_type of entry 0. Entry i owns tag `TAG_BASE`+i, and all of these must be distinct, non-`INVALID` values.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `FLUSH` in 1: synchronous clear of all entries.
- `DISPATCH_VALID` in 1: the issue queue presents a task.
- `DISPATCH_READY` out 1: at least one entry is free.
- `DISPATCH_TASK` in task_t: opcode, alu_fun and mem_type of the task.
- `T1`, `T2`, `T3` in RS_tag_type: producer tags from the MAP table; `INVALID` means the value is available now.
- `A`, `B`, `RS2_DATA` in 32: source values used when the matching tag is `INVALID`.
- `cdb_in` in cdb_t: CDB tag/data broadcast; a broadcast is present when `cdb_in.tag` != `INVALID`.
- `ISSUE_VALID` out 1: a ready entry is presented to the FU.
- `ISSUE_READY` in 1: the FU accepts the presented entry.
- `V1`, `V2`, `V3` out 32: operands of the presented entry.
- `rd_tag` out RS_tag_type: tag of the presented entry.
- `alu_fun` out 4, `mem_type` out 3: fields of the presented task.
- `COUNT` out $clog2(DEPTH+1): number of occupied entries.
- `BUSY` out 1: asserted when `COUNT`==`DEPTH`.

## Operation
- **Entry contents.** Each entry holds valid, task, and for each of the 3 sources a tag, a 32-bit value and a ready bit. Each entry also holds an age rank.
- **Dispatch.** A dispatch fires on `DISPATCH_VALID`&&`DISPATCH_READY`. The task is written into the lowest-index free entry.
- **Source capture at dispatch.** For each source:
  - tag `INVALID`: ready=1, value taken from the input (V1←A, V2←B, V3←RS2_DATA).
  - tag equals the current `cdb_in.tag`: ready=1, value taken from `cdb_in.data`. This is the dispatch bypass.
  - otherwise: ready=0 and the tag is stored.
- **Wake-up.** Every cycle, each valid entry compares every non-ready source tag against `cdb_in.tag`. On a match it sets ready and captures the data. One broadcast may wake any number of sources in any number of entries.
- **Select.** The bank presents the oldest valid entry whose 3 ready bits are all set.
  - Age is allocation order and is preserved across frees. Ties cannot occur.
  - If no entry is ready, `ISSUE_VALID`=0 and the outputs read 0, with `rd_tag`=`INVALID`.
- **Issue.** On `ISSUE_VALID`&&`ISSUE_READY` the presented entry is freed at the clock edge. If `ISSUE_READY` is low, the same entry stays presented with stable outputs unless an older entry becomes ready. An older entry always preempts the presented one.
- **Full/empty.**
  - `DISPATCH_READY`=!`BUSY`. A slot freed by issue in cycle n becomes usable for dispatch in cycle n+1, never in the same cycle.
  - On an empty bank, `ISSUE_VALID`=0.
- **Simultaneous events.**
  - Dispatch and issue in the same cycle: `COUNT` is unchanged.
  - CDB match and issue of the matching entry in the same cycle: the entry is freed and the match is ignored.
- **Flush.** `FLUSH` clears every valid bit and `COUNT` at the next edge. It has priority over dispatch and issue in the same cycle.
- **Reset.** `RST_N` low clears immediately, mid-operation included. Values while reset is held:
  - all valid bits 0, `COUNT`=0, `BUSY`=0, `DISPATCH_READY`=1
  - `ISSUE_VALID`=0, `V1`/`V2`/`V3`=0, `alu_fun`=0, `mem_type`=0, `rd_tag`=`INVALID`

## Timing
- **Dispatch to issue.** A task dispatched with all sources ready shows `ISSUE_VALID` in the next cycle. Minimum residency is 1 cycle.
- **CDB to issue.** With a CDB broadcast completing an entry's last source in cycle n, the entry is issuable in cycle n+1 (macro off) or in cycle n (macro on).
- **Output path.** The select and output mux are combinational from registered state, plus the CDB when the macro is on.
- **COUNT.** Updated at the edge: +1 per dispatch, −1 per issue.

## Configuration
- **Macro:** `RS_BANK_CDB_WAKEUP_BYPASS_EN`.
- **Defined:** an entry whose last missing source matches `cdb_in.tag` in the current cycle is eligible for select in that cycle. The missing operand is driven from `cdb_in.data`, and the value is also stored.
- **Undefined:** select uses registered ready bits only, which adds one cycle of wake-up latency and removes the CDB→output combinational path.

## Test plan
- **Ready dispatch.** Reset, then dispatch T1=T2=T3=`INVALID`, A=5, B=7, RS2_DATA=9. Next cycle: `ISSUE_VALID`=1, V1=5, V2=7, V3=9, rd_tag=`TAG_BASE`. Assert ISSUE_READY; the following cycle `COUNT`=0.
- **CDB wake-up.** Dispatch T1=tag X with other sources `INVALID`. Broadcast X/0xDEAD in cycle n. Required: V1=0xDEAD, `ISSUE_VALID` rising at cycle n+1 (macro off) or cycle n (macro on).
- **Oldest-first.** Dispatch entries E0 and E1, both waiting on tag X, with E1 dispatched later. Broadcast X: E0 is presented first. E1 is presented after E0 issues.
- **Full bank.** Fill `DEPTH`=4 entries: `BUSY`=1, `DISPATCH_READY`=0, and a held `DISPATCH_VALID` is not accepted. Issue one entry: `DISPATCH_READY`=1 the next cycle and the held dispatch is written.
- **FU backpressure.** Present an entry with `ISSUE_READY`=0 for 3 cycles: outputs stay stable and `COUNT` is unchanged.
- **Flush and reset.** Assert `FLUSH` together with a dispatch: `COUNT`=0 next cycle. Drop `RST_N` mid-wake-up: `ISSUE_VALID`=0 immediately and all outputs at their reset values.
